wishbone_bus_if: RTL and testbench



---
 rtl/wishbone_bus_if.sv | 140 ++++++++++++++
 tb/tb_wishbone_bus_if.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if.sv
// Bridges the core's data-memory port onto a Wishbone B4 classic bus as
// registered single-beat cycles, stalling the pipeline while a cycle is open.
module wishbone_bus_if #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   rd_buf_q, rd_buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          we_q, we_d, act_q, act_d;
  logic [3:0]    sel_q, sel_d;
  logic          timeout;

  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    sel_d      = sel_q;
    act_d      = act_q;
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state_q)
      S_IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_data_i;
          we_d    = cpu_we_i;
          sel_d   = cpu_sel_i;
          act_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Any way out of BUSY drops the whole bus back to zero.
        if (flush_i || wishbone_ack_i || timeout) begin
          addr_d  = '0;
          wdata_d = '0;
          we_d    = 1'b0;
          sel_d   = '0;
          act_d   = 1'b0;
        end
        if (flush_i) begin
          rd_buf_d = '0;
          state_d  = S_IDLE;
        end else if (wishbone_ack_i) begin
          if (!we_q) begin
            rd_buf_d   = wishbone_data_i;
            cpu_data_o = wishbone_data_i;
          end
          state_d = (stall_i != '0) ? S_WAIT : S_IDLE;
        end else if (timeout) begin
          rd_buf_d = '0;
          err_d    = 1'b1;
          state_d  = (stall_i != '0) ? S_WAIT : S_IDLE;
        end else begin
          stallreq_o = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // Load data is held here until the pipeline is ready to take it.
        cpu_data_o = rd_buf_q;
        if (stall_i == '0 || flush_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rd_buf_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      act_q    <= act_d;
    end
  end

  assign err_o           = err_q;
  assign wishbone_addr_o = addr_q;
  assign wishbone_data_o = wdata_q;
  assign wishbone_we_o   = we_q;
  assign wishbone_sel_o  = sel_q;
  assign wishbone_stb_o  = act_q;
  assign wishbone_cyc_o  = act_q;

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Bench for wishbone_bus_if: directed scenarios plus a randomized transaction
// stream checked against a transaction-level reference model.
module tb_wishbone_bus_if;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic        cpu_we_i = 1'b0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        err_o;
  logic [31:0] wb_din = '0;
  logic        wb_ack = 1'b0;
  logic [31:0] wb_addr, wb_dout;
  logic        wb_we, wb_stb, wb_cyc;
  logic [3:0]  wb_sel;

  int errors = 0;
  int checks = 0;

  wishbone_bus_if #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .err_o(err_o),
    .wishbone_data_i(wb_din), .wishbone_ack_i(wb_ack),
    .wishbone_addr_o(wb_addr), .wishbone_data_o(wb_dout), .wishbone_we_o(wb_we),
    .wishbone_sel_o(wb_sel), .wishbone_stb_o(wb_stb), .wishbone_cyc_o(wb_cyc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] sel);
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data; cpu_sel_i = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if ({wb_stb, wb_cyc, wb_we, wb_addr, wb_dout, wb_sel, err_o, stallreq_o, cpu_data_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got stb=%b addr=%h data=%h cpu=%h", wb_stb, wb_addr, wb_dout, cpu_data_o);
    end
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if ({wb_stb, wb_cyc, err_o, stallreq_o, cpu_data_o} !== '0) begin
      errors++; $display("FAIL reset_release: got stb=%b err=%b sreq=%b cpu=%h, expected zeros", wb_stb, err_o, stallreq_o, cpu_data_o);
    end
  endtask

  task automatic test_read_wait();
    int hi = 0;
    issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    #1; hi += int'(stallreq_o);
    step();
    checks++;
    if ({wb_stb, wb_cyc, wb_we, wb_addr} !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL read_bus: got stb=%b cyc=%b we=%b addr=%h, expected 1 1 0 00000100", wb_stb, wb_cyc, wb_we, wb_addr);
    end
    hi += int'(stallreq_o);
    step();
    hi += int'(stallreq_o);
    step();
    wb_ack = 1'b1; wb_din = 32'hDEADBEEF;
    #1;
    hi += int'(stallreq_o);
    checks++;
    if (hi != 3) begin
      errors++; $display("FAIL read_stallreq_cycles: got %0d, expected 3", hi);
    end
    checks++;
    if (cpu_data_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_data: got %h, expected deadbeef", cpu_data_o);
    end
    step();
    wb_ack = 1'b0; cpu_ce_i = 1'b0; wb_din = 32'h0;
    #1;
    checks++;
    if ({wb_stb, wb_cyc, stallreq_o} !== 3'b000) begin
      errors++; $display("FAIL read_release: got stb=%b cyc=%b sreq=%b, expected 000", wb_stb, wb_cyc, stallreq_o);
    end
  endtask

  task automatic test_write();
    issue(1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011);
    step();
    cpu_ce_i = 1'b0;
    checks++;
    if ({wb_stb, wb_cyc, wb_we, wb_sel, wb_addr, wb_dout} !== {3'b111, 4'b0011, 32'h10, 32'h1234_5678}) begin
      errors++; $display("FAIL write_bus: got we=%b sel=%b addr=%h data=%h", wb_we, wb_sel, wb_addr, wb_dout);
    end
    // Ack with junk on the read bus while stalled: WAIT exposes the untouched read buffer.
    wb_ack = 1'b1; wb_din = 32'h5555_AAAA; stall_i = 6'b000001;
    #1;
    checks++;
    if ({stallreq_o, cpu_data_o} !== 33'h0) begin
      errors++; $display("FAIL write_ack: got sreq=%b cpu=%h, expected 0 00000000", stallreq_o, cpu_data_o);
    end
    step();
    wb_ack = 1'b0; wb_din = '0;
    #1;
    checks++;
    if (cpu_data_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_rdbuf_kept: got %h, expected deadbeef", cpu_data_o);
    end
    stall_i = '0;
    step();
  endtask

  task automatic test_held_stall();
    issue(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    wb_ack = 1'b1; wb_din = 32'hA5A5_A5A5; stall_i = 6'b001111;
    #1;
    checks++;
    if ({stallreq_o, cpu_data_o} !== {1'b0, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL held_ack: got sreq=%b cpu=%h", stallreq_o, cpu_data_o);
    end
    step();
    wb_ack = 1'b0; wb_din = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_i = '0;
      #1;
      checks++;
      if ({wb_stb, stallreq_o, cpu_data_o} !== {2'b00, 32'hA5A5_A5A5}) begin
        errors++; $display("FAIL held_wait%0d: got stb=%b sreq=%b cpu=%h", i, wb_stb, stallreq_o, cpu_data_o);
      end
      step();
    end
    cpu_ce_i = 1'b1;
    #1;
    checks++;
    if ({stallreq_o, cpu_data_o} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL held_back_idle: got sreq=%b cpu=%h, expected 1 00000000", stallreq_o, cpu_data_o);
    end
    cpu_ce_i = 1'b0;
    #1;
  endtask

  task automatic test_flush();
    issue(1'b0, 32'h0000_0300, 32'h0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    step();
    flush_i = 1'b1;
    #1;
    checks++;
    if ({stallreq_o, cpu_data_o} !== 33'h0) begin
      errors++; $display("FAIL flush_cycle: got sreq=%b cpu=%h, expected 0 00000000", stallreq_o, cpu_data_o);
    end
    step();
    flush_i = 1'b0; wb_ack = 1'b1; wb_din = 32'h1111_1111;
    #1;
    checks++;
    if ({wb_stb, wb_cyc, stallreq_o, cpu_data_o} !== 35'h0) begin
      errors++; $display("FAIL flush_late_ack: got stb=%b cyc=%b sreq=%b cpu=%h", wb_stb, wb_cyc, stallreq_o, cpu_data_o);
    end
    step();
    wb_ack = 1'b0; wb_din = '0;
    // The flush must also have emptied the read buffer; a stalled write reveals it.
    issue(1'b1, 32'h0000_0304, 32'h0, 4'h1);
    step();
    cpu_ce_i = 1'b0; wb_ack = 1'b1; stall_i = 6'b100000;
    step();
    wb_ack = 1'b0;
    #1;
    checks++;
    if (cpu_data_o !== 32'h0) begin
      errors++; $display("FAIL flush_rdbuf_cleared: got %h, expected 00000000", cpu_data_o);
    end
    stall_i = '0;
    step();
  endtask

  task automatic test_timeout();
    int stb_n = 0, err_n = 0, err_at = -1, nz = 0;
    issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stb_n += int'(wb_stb);
      if (err_o) begin err_n++; err_at = i; end
      if (cpu_data_o != 32'h0) nz++;
      step();
    end
    checks++;
    if (stb_n != TO) begin
      errors++; $display("FAIL timeout_stb_cycles: got %0d, expected %0d", stb_n, TO);
    end
    checks++;
    if (err_n != 1 || err_at != TO) begin
      errors++; $display("FAIL timeout_err_pulse: got count=%0d at=%0d, expected 1 at %0d", err_n, err_at, TO);
    end
    checks++;
    if (nz != 0) begin
      errors++; $display("FAIL timeout_cpu_data: got %0d nonzero cycles, expected 0", nz);
    end
    cpu_ce_i = 1'b1;
    #1;
    checks++;
    if (stallreq_o !== 1'b1) begin
      errors++; $display("FAIL timeout_back_idle: got sreq=%b, expected 1", stallreq_o);
    end
    cpu_ce_i = 1'b0;
    #1;
  endtask

  task automatic test_async_reset();
    issue(1'b1, 32'h0000_0500, 32'hFFFF_FFFF, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({wb_stb, wb_cyc, wb_we, wb_addr, wb_dout, wb_sel, err_o, stallreq_o, cpu_data_o} !== '0) begin
      errors++; $display("FAIL async_reset: got stb=%b we=%b addr=%h data=%h sel=%b", wb_stb, wb_we, wb_addr, wb_dout, wb_sel);
    end
    rst = 1'b0;
    step();
    issue(1'b0, 32'h0000_0600, 32'h0, 4'hF);
    step();
    cpu_ce_i = 1'b0;
    checks++;
    if ({wb_stb, wb_we, wb_addr} !== {2'b10, 32'h600}) begin
      errors++; $display("FAIL async_after_bus: got stb=%b we=%b addr=%h", wb_stb, wb_we, wb_addr);
    end
    wb_ack = 1'b1; wb_din = 32'hCAFE_F00D;
    #1;
    checks++;
    if (cpu_data_o !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL async_after_data: got %h, expected cafef00d", cpu_data_o);
    end
    step();
    wb_ack = 1'b0; wb_din = '0;
  endtask

  // Transaction-level model: an access lasts min(waits+1, TO) bus cycles, a
  // timeout yields zero data plus an err pulse, reads refresh the buffer.
  task automatic test_random();
    logic [31:0] rd_model = '0;
    logic        pend_err = 1'b0;
    rst = 1'b1; #1; rst = 1'b0;
    step();
    for (int t = 0; t < 60; t++) begin
      logic        we   = 1'($urandom_range(0, 1));
      logic [31:0] addr = $urandom;
      logic [31:0] data = $urandom;
      logic [3:0]  sel  = 4'($urandom);
      logic [31:0] ad   = $urandom;
      int          waits = $urandom_range(0, 5);
      int          hold  = $urandom_range(0, 2);
      logic        to    = (waits >= TO);
      logic [31:0] exp_d;
      issue(we, addr, data, sel);
      stall_i = '0;
      #1;
      checks++;
      if ({wb_stb, stallreq_o, cpu_data_o, err_o} !== {2'b01, 32'h0, pend_err}) begin
        errors++; $display("FAIL rnd%0d_idle: got stb=%b sreq=%b cpu=%h err=%b exp err=%b", t, wb_stb, stallreq_o, cpu_data_o, err_o, pend_err);
      end
      pend_err = 1'b0;
      step();
      cpu_ce_i = 1'b0;
      for (int k = 0; k < TO; k++) begin
        logic last = to ? (k == TO - 1) : (k == waits);
        wb_din = $urandom;
        stall_i = last ? (hold > 0 ? 6'($urandom_range(1, 63)) : 6'd0) : 6'($urandom);
        wb_ack = last && !to;
        exp_d = (last && !to && !we) ? ad : 32'h0;
        if (wb_ack) wb_din = ad;
        #1;
        checks++;
        if ({wb_stb, wb_cyc, wb_we, wb_addr, wb_dout, wb_sel, stallreq_o, cpu_data_o} !==
            {2'b11, we, addr, data, sel, !last, exp_d}) begin
          errors++; $display("FAIL rnd%0d_busy%0d: got we=%b addr=%h data=%h sel=%b sreq=%b cpu=%h exp sreq=%b cpu=%h",
                             t, k, wb_we, wb_addr, wb_dout, wb_sel, stallreq_o, cpu_data_o, !last, exp_d);
        end
        step();
        if (last) break;
      end
      wb_ack = 1'b0;
      wb_din = $urandom;
      if (to) rd_model = '0;
      else if (!we) rd_model = ad;
      pend_err = to;
      if (hold > 0) begin
        for (int h = 0; h <= hold; h++) begin
          stall_i = (h < hold) ? 6'($urandom_range(1, 63)) : 6'd0;
          #1;
          checks++;
          if ({wb_stb, stallreq_o, cpu_data_o, err_o} !== {2'b00, rd_model, pend_err}) begin
            errors++; $display("FAIL rnd%0d_wait%0d: got stb=%b sreq=%b cpu=%h err=%b exp cpu=%h err=%b",
                               t, h, wb_stb, stallreq_o, cpu_data_o, err_o, rd_model, pend_err);
          end
          pend_err = 1'b0;
          step();
        end
      end
    end
    stall_i = '0;
    #1;
    checks++;
    if ({wb_stb, err_o} !== {1'b0, pend_err}) begin
      errors++; $display("FAIL rnd_tail: got stb=%b err=%b, expected 0 %b", wb_stb, err_o, pend_err);
    end
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_write();
    test_held_stall();
    test_flush();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
